// File: rtl/spi_master_gen.sv
// SPI master: range-checked {data, addr, wr} frames shifted LSB first.
// Writes then wait for op_done; reads wait for ready and clock in the reply.
module spi_master_gen #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MAX_ADDR = 32,
  parameter int CLK_DIV  = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              newd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  input  logic              ready_i,
  input  logic              op_done_i
);

  localparam int FRAME_W = DATA_W + ADDR_W + 1;
  localparam int DIV_N   = 2 * CLK_DIV;
  localparam int DIV_W   = $clog2(DIV_N);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int TMO_W   = $clog2(TIMEOUT);

  localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_N - 1);
  localparam logic [BIT_W-1:0] BITS_WR   = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BITS_RD   = BIT_W'(ADDR_W);
  localparam logic [BIT_W-1:0] BITS_DATA = BIT_W'(DATA_W - 1);
  // The wait counter would reach TIMEOUT-1 on this edge, so this is the last wait cycle.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_CHECK      = 3'd2,
    ST_SEND       = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_WAIT_READY = 3'd5,
    ST_READ       = 3'd6,
    ST_ERROR      = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic               done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W:0]    rx_shift_s;
  logic               bit_end_s;
  logic               addr_bad_s;

  assign rx_shift_s = {miso_i, rx_q};
  assign bit_end_s  = (div_q == DIV_LAST);
  assign addr_bad_s = (32'(frame_q[ADDR_W:1]) >= 32'(MAX_ADDR));

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      wr_q    <= 1'b0;
      rx_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      tmo_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      wr_q    <= wr_d;
      rx_q    <= rx_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tmo_q   <= tmo_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    wr_d    = wr_q;
    rx_d    = rx_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tmo_d   = tmo_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (newd_i) begin
          frame_d = {din_i, addr_i, wr_i};
          wr_d    = wr_i;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_CHECK;
      ST_CHECK: begin
        if (addr_bad_s) begin
          state_d = ST_ERROR;
        end else begin
          cs_d    = 1'b0;
          mosi_d  = frame_q[0];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (div_q == DIV_RISE) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = sclk_q;
        end
        if (bit_end_s) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q == (wr_q ? BITS_WR : BITS_RD)) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            bit_d   = '0;
            tmo_d   = '0;
            state_d = wr_q ? ST_WAIT_DONE : ST_WAIT_READY;
          end else begin
            bit_d   = bit_q + 1'b1;
            frame_d = frame_q >> 1;
            mosi_d  = frame_q[1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (op_done_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_READY: begin
        if (ready_i) begin
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_READ;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_READ: begin
        // miso is captured on the same edge that raises sclk.
        if (div_q == DIV_RISE) begin
          sclk_d = 1'b1;
          rx_d   = rx_shift_s[DATA_W:1];
        end else begin
          rx_d = rx_q;
        end
        if (bit_end_s) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (bit_q == BITS_DATA) begin
            cs_d    = 1'b1;
            dout_d  = rx_q;
            done_d  = 1'b1;
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_ERROR: begin
        cs_d    = 1'b1;
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign dout_o = dout_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;
  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen with a small SPI slave monitor/driver.
module tb_spi_master_gen;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       newd_i = 1'b0, wr_i = 1'b0, ready_i = 1'b0, op_done_i = 1'b0;
  logic [7:0] addr_i = 8'h00, din_i = 8'h00;
  logic [7:0] dout_o;
  logic       done_o, err_o, busy_o, cs_o, sclk_o, mosi_o, miso_i;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] mosi_hist = 64'h0;
  int          mosi_total = 0;
  int          cs_low_total = 0;
  int          done_total = 0;
  logic        rd_phase = 1'b0;
  int          rd_base = 0;
  logic [7:0]  miso_pat = 8'h00;

  always #5 clk_i = ~clk_i;

  spi_master_gen #(.DATA_W(8), .ADDR_W(8), .MAX_ADDR(32), .CLK_DIV(2), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .newd_i(newd_i), .wr_i(wr_i), .addr_i(addr_i),
    .din_i(din_i), .dout_o(dout_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .cs_o(cs_o), .sclk_o(sclk_o), .mosi_o(mosi_o), .miso_i(miso_i), .ready_i(ready_i),
    .op_done_i(op_done_i)
  );

  // Slave drives the reply bit indexed by how many sclk rises the read has seen so far.
  assign miso_i = (rd_phase && ((mosi_total - rd_base) < 8)) ? miso_pat[3'(mosi_total - rd_base)] : 1'b0;

  always @(posedge sclk_o) begin
    if (!cs_o) begin
      mosi_hist  <= {mosi_o, mosi_hist[63:1]};
      mosi_total <= mosi_total + 1;
    end
  end

  always @(negedge clk_i) begin
    if (!cs_o) cs_low_total <= cs_low_total + 1;
    if (done_o) done_total <= done_total + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] last_frame(input int n);
    logic [63:0] t;
    t = mosi_hist >> (64 - n);
    return t[31:0];
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic start_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    wr_i = w; addr_i = a; din_i = d; newd_i = 1'b1;
    tick();
    newd_i = 1'b0;
  endtask

  task automatic wait_cs_rise(input int budget, output logic ok);
    logic seen_low;
    seen_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!cs_o) seen_low = 1'b1;
      else if (seen_low) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_o) begin cyc = i; break; end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cyc, m0, c0, d0;
    logic [31:0] exp_w;

    repeat (3) tick();
    check_eq("rst_cs", 32'(cs_o), 32'd1);
    check_eq("rst_sclk", 32'(sclk_o), 32'd0);
    check_eq("rst_mosi", 32'(mosi_o), 32'd0);
    check_eq("rst_done_err_busy", {29'd0, done_o, err_o, busy_o}, 32'd0);
    check_eq("rst_dout", 32'(dout_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Write 0xA5 to 0x05, op_done three cycles after cs rises.
    m0 = mosi_total; c0 = cs_low_total; d0 = done_total;
    start_req(1'b1, 8'h05, 8'hA5);
    check_eq("wr_busy", 32'(busy_o), 32'd1);
    wait_cs_rise(200, ok);
    check_eq("wr_cs_rise", 32'(ok), 32'd1);
    exp_w = 32'({8'hA5, 8'h05, 1'b1});
    check_eq("wr_bits", 32'(mosi_total - m0), 32'd17);
    check_eq("wr_frame", last_frame(17), exp_w);
    check_eq("wr_cs_window", 32'(cs_low_total - c0), 32'd68);
    repeat (3) tick();
    op_done_i = 1'b1;
    tick();
    op_done_i = 1'b0;
    check_eq("wr_done_err", {30'd0, done_o, err_o}, 32'd2);
    check_eq("wr_idle", 32'(busy_o), 32'd0);
    tick();
    check_eq("wr_done_pulse", 32'(done_total - d0), 32'd1);

    // Read from 0x1F, ready five cycles after cs rises, reply 0x3C.
    m0 = mosi_total;
    miso_pat = 8'h3C;
    start_req(1'b0, 8'h1F, 8'hFF);
    wait_cs_rise(200, ok);
    check_eq("rd_cs_rise", 32'(ok), 32'd1);
    check_eq("rd_bits", 32'(mosi_total - m0), 32'd9);
    check_eq("rd_frame", last_frame(9), 32'({8'h1F, 1'b0}));
    repeat (5) tick();
    rd_base = mosi_total; rd_phase = 1'b1; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    wait_done(100, cyc);
    check_eq("rd_done_seen", 32'(cyc > 0), 32'd1);
    check_eq("rd_err", 32'(err_o), 32'd0);
    check_eq("rd_dout", 32'(dout_o), 32'h3C);
    rd_phase = 1'b0;
    tick();
    check_eq("rd_dout_hold", {23'd0, done_o, dout_o}, 32'h03C);

    // Out-of-range address: error three cycles after newd is sampled, cs untouched.
    c0 = cs_low_total;
    start_req(1'b1, 8'h20, 8'h11);
    wait_done(20, cyc);
    check_eq("range_latency", 32'(cyc), 32'd3);
    check_eq("range_err", 32'(err_o), 32'd1);
    check_eq("range_cs", 32'(cs_low_total - c0), 32'd0);
    tick();
    check_eq("range_pulse", {30'd0, done_o, err_o}, 32'd0);

    // Write with no op_done: timeout error 64 cycles after cs rises.
    start_req(1'b1, 8'h03, 8'h5A);
    wait_cs_rise(200, ok);
    wait_done(200, cyc);
    check_eq("tmo_latency", 32'(cyc), 32'd64);
    check_eq("tmo_err", 32'(err_o), 32'd1);
    tick();

    // op_done on the final wait cycle wins over the timeout.
    start_req(1'b1, 8'h04, 8'h77);
    wait_cs_rise(200, ok);
    repeat (62) tick();
    op_done_i = 1'b1;
    tick();
    op_done_i = 1'b0;
    check_eq("tmo_wr_win", {30'd0, done_o, err_o}, 32'd2);
    tick();

    // ready on the final wait cycle wins over the timeout.
    miso_pat = 8'hA6;
    start_req(1'b0, 8'h1E, 8'h00);
    wait_cs_rise(200, ok);
    repeat (62) tick();
    rd_base = mosi_total; rd_phase = 1'b1; ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check_eq("tmo_rd_cs", 32'(cs_o), 32'd0);
    wait_done(100, cyc);
    check_eq("tmo_rd_win", {23'd0, err_o, dout_o}, 32'h0A6);
    rd_phase = 1'b0;
    tick();

    // Reset during bit 6 of a write aborts at once with no done.
    d0 = done_total;
    start_req(1'b1, 8'h07, 8'hC3);
    repeat (2) tick();
    check_eq("abort_cs_low", 32'(cs_o), 32'd0);
    repeat (25) tick();
    rst_ni = 1'b0;
    #1;
    check_eq("abort_outs", {28'd0, cs_o, sclk_o, mosi_o, busy_o}, 32'h8);
    tick();
    rst_ni = 1'b1;
    tick();
    check_eq("abort_no_done", 32'(done_total - d0), 32'd0);
    m0 = mosi_total;
    start_req(1'b1, 8'h0A, 8'h3C);
    wait_cs_rise(200, ok);
    check_eq("post_rst_frame", last_frame(17), 32'({8'h3C, 8'h0A, 1'b1}));
    check_eq("post_rst_bits", 32'(mosi_total - m0), 32'd17);
    op_done_i = 1'b1;
    tick();
    op_done_i = 1'b0;
    check_eq("post_rst_done", {30'd0, done_o, err_o}, 32'd2);
    tick();

    // newd during SEND is ignored: one frame, one done.
    d0 = done_total; c0 = cs_low_total;
    start_req(1'b1, 8'h11, 8'hC3);
    repeat (12) tick();
    start_req(1'b1, 8'h02, 8'hFF);
    wait_cs_rise(200, ok);
    check_eq("busy_frame", last_frame(17), 32'({8'hC3, 8'h11, 1'b1}));
    op_done_i = 1'b1;
    tick();
    op_done_i = 1'b0;
    repeat (80) tick();
    check_eq("busy_one_done", 32'(done_total - d0), 32'd1);
    check_eq("busy_one_frame", 32'(cs_low_total - c0), 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
